cnn_result_reader: RTL and testbench

- Reader/drain side of the 4x4 cellular-network tile.
- Waits a programmed number of tile sweeps, then snapshots the tile's 16 parallel 9-bit Y outputs in one cycle.
- Streams the snapshot out one cell per transfer over a valid/ready handshake, in order Y1..Y16.
- Sits between the tile and the host/readback path; one snapshot per start command.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_y_buffer.sv | 43 ++++
 rtl/cnn_result_reader.sv | 137 +++++++++++++
 tb/tb_cnn_result_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and types for the CNN tile result reader
package cnn_pkg;

  localparam int N_CELLS = 16;
  localparam int Y_W     = 9;
  localparam int ITER_W  = 8;

  typedef logic [3:0] cell_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    STREAM,
    FIN
  } rd_state_t;

endpackage

// File: rtl/cnn_y_buffer.sv
// rtl/cnn_y_buffer.sv - 16-cell Y capture register with registered index-select read
module cnn_y_buffer
  import cnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [N_CELLS*Y_W-1:0] y_i,
  input  cell_idx_t              rd_idx_i,
  output logic [Y_W-1:0]         rd_data_o
);

  logic [Y_W-1:0] mem_q [N_CELLS];
  logic [Y_W-1:0] rd_data_q, rd_data_d;

  // rd_idx_i is the index presented next cycle; on a load the incoming slice
  // bypasses the array so beat 0 is ready right after the capture edge.
  always_comb begin
    rd_data_d = mem_q[rd_idx_i];
    if (load_i) begin
      rd_data_d = y_i[rd_idx_i*Y_W +: Y_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CELLS; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (load_i) begin
        for (int i = 0; i < N_CELLS; i++) begin
          mem_q[i] <= y_i[i*Y_W +: Y_W];
        end
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cnn_result_reader.sv
// rtl/cnn_result_reader.sv - sweep-counted tile snapshot and Y1..Y16 stream; CNN_CONV_CHECK_EN adds early convergence capture
module cnn_result_reader
  import cnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ITER_W-1:0]      iter_count,
  input  logic                   sweep_done,
  input  logic [N_CELLS*Y_W-1:0] y_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Y_W-1:0]         out_data,
  output logic [3:0]             out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic                   converged
);

  rd_state_t         state_q, state_d;
  logic [ITER_W-1:0] remaining_q, remaining_d;
  cell_idx_t         idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic              load;
  logic              early;

`ifdef CNN_CONV_CHECK_EN
  logic [N_CELLS*Y_W-1:0] snap_q, snap_d;
  logic                   seen_q, seen_d;
  logic                   conv_q, conv_d;

  // Only a sweep after the first one of this command has a valid snapshot to compare.
  assign early = seen_q && (y_in == snap_q);

  always_comb begin
    snap_d = snap_q;
    seen_d = seen_q;
    conv_d = conv_q;
    if (state_q == IDLE && start) begin
      seen_d = 1'b0;
      conv_d = 1'b0;
    end else if (state_q == SETTLE && sweep_done) begin
      snap_d = y_in;
      seen_d = 1'b1;
      if (early) conv_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      seen_q <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      snap_q <= snap_d;
      seen_q <= seen_d;
      conv_q <= conv_d;
    end
  end

  assign converged = conv_q;
`else
  assign early     = 1'b0;
  assign converged = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    overrun_d   = overrun_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SETTLE;
          remaining_d = (iter_count == '0) ? ITER_W'(1) : iter_count;
          overrun_d   = 1'b0;
        end
      end
      SETTLE: begin
        // The <= guard keeps the counter from ever wrapping below one.
        if (sweep_done) begin
          if (early || remaining_q <= ITER_W'(1)) begin
            load    = 1'b1;
            idx_d   = '0;
            state_d = STREAM;
          end else begin
            remaining_d = remaining_q - ITER_W'(1);
          end
        end
      end
      STREAM: begin
        if (sweep_done) overrun_d = 1'b1;
        if (out_ready) begin
          if (idx_q == 4'd15) state_d = FIN;
          else                idx_d   = idx_q + 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
    end
  end

  cnn_y_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .y_i       (y_in),
    .rd_idx_i  (idx_d),
    .rd_data_o (out_data)
  );

  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (idx_q == 4'd15);
  assign out_index = idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cnn_result_reader.sv
// tb/tb_cnn_result_reader.sv - scoreboard bench for cnn_result_reader
module tb_cnn_result_reader;
  import cnn_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   start = 1'b0;
  logic                   sweep_done = 1'b0;
  logic                   out_ready = 1'b0;
  logic [ITER_W-1:0]      iter_count = '0;
  logic [N_CELLS*Y_W-1:0] y_in = '0;
  logic                   out_valid, out_last, busy, done, overrun, converged;
  logic [Y_W-1:0]         out_data;
  logic [3:0]             out_index;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int beats_seen = 0;
  int done_seen = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;

  typedef struct packed {
    logic [Y_W-1:0] data;
    logic [3:0]     idx;
    logic           last;
  } beat_t;

  beat_t sb[$];

  cnn_result_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .iter_count (iter_count),
    .sweep_done (sweep_done),
    .y_in       (y_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .converged  (converged)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N_CELLS*Y_W-1:0] pat(int base, int step);
    logic [N_CELLS*Y_W-1:0] v;
    for (int k = 0; k < N_CELLS; k++) begin
      int x;
      x = base + step * k;
      v[k*Y_W +: Y_W] = x[Y_W-1:0];
    end
    return v;
  endfunction

  task automatic push_stream(int base, int step);
    for (int k = 0; k < N_CELLS; k++) begin
      beat_t b;
      int x;
      x = base + step * k;
      b.data = x[Y_W-1:0];
      b.idx  = k[3:0];
      b.last = (k == N_CELLS - 1);
      sb.push_back(b);
    end
  endtask

  // Monitor: beats, stall stability and the done pulse, sampled on the falling edge.
  logic           stall_q = 1'b0;
  logic           done_due = 1'b0;
  logic [Y_W-1:0] stall_data;
  logic [3:0]     stall_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q  = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        chk("done_pulse", done, 1);
        if (done) done_seen++;
        done_due = 1'b0;
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got 1 expected 0");
      end
      if (stall_q && out_valid) begin
        chk("stall_data", out_data, stall_data);
        chk("stall_idx", out_index, stall_idx);
      end
      stall_q = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got idx %0d expected none", out_index);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_idx", out_index, e.idx);
          chk("beat_last", out_last, e.last);
        end
        if (beats_seen == 0) first_xfer_cyc = cycle;
        last_xfer_cyc = cycle;
        beats_seen++;
        if (out_last) done_due = 1'b1;
      end else if (out_valid) begin
        stall_q    = 1'b1;
        stall_data = out_data;
        stall_idx  = out_index;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int n);
    iter_count = n[ITER_W-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_sweep();
    sweep_done = 1'b1;
    tick();
    sweep_done = 1'b0;
  endtask

  task automatic wait_done(bit bp, int budget);
    int d0;
    int n;
    int stall_n;
    d0 = done_seen;
    n = 0;
    stall_n = 0;
    while (done_seen == d0 && n < budget) begin
      if (bp) begin
        if (beats_seen == 6 && stall_n < 5) begin
          out_ready = 1'b0;
          stall_n++;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        out_ready = 1'b1;
      end
      tick();
      n++;
    end
    chk("done_seen", (done_seen != d0), 1);
    chk("sb_empty", sb.size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_converged"}, converged, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    int cap;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic readback: Y(k) = k-8, three sweeps, ready held high.
    beats_seen = 0;
    push_stream(-7, 1);
    y_in = pat(-7, 1);
    out_ready = 1'b1;
    do_start(3);
    chk("basic_busy", busy, 1);
    do_sweep();
    do_sweep();
    chk("basic_not_yet", out_valid, 0);
    do_sweep();
    chk("basic_first_valid", out_valid, 1);
    wait_done(0, 100);
    chk("basic_back_to_back", last_xfer_cyc - first_xfer_cyc, 15);
    chk("basic_idle_busy", busy, 0);

    // Backpressure with random ready and a 5-cycle stall on beat 7.
    beats_seen = 0;
    push_stream(-120, 13);
    y_in = pat(-120, 13);
    out_ready = 1'b0;
    do_start(1);
    do_sweep();
    wait_done(1, 400);

    // Zero count and a y_in change right after capture.
    beats_seen = 0;
    push_stream(-15, -15);
    do_start(0);
    chk("zero_not_yet", out_valid, 0);
    y_in = pat(-15, -15);
    do_sweep();
    chk("zero_capture", out_valid, 1);
    y_in = pat(100, 5);
    wait_done(0, 100);

    // Overrun and ignored start during STREAM.
    beats_seen = 0;
    push_stream(30, -4);
    y_in = pat(30, -4);
    out_ready = 1'b0;
    do_start(1);
    do_sweep();
    chk("ovr_valid", out_valid, 1);
    y_in = pat(0, 0);
    iter_count = 8'd5;
    sweep_done = 1'b1;
    start = 1'b1;
    tick();
    sweep_done = 1'b0;
    start = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_index_held", out_index, 0);
    wait_done(0, 100);
    chk("ovr_sticky", overrun, 1);
    beats_seen = 0;
    do_start(1);
    chk("ovr_cleared", overrun, 0);
    push_stream(-128, 17);
    y_in = pat(-128, 17);
    do_sweep();
    wait_done(0, 100);

    // Async reset mid-beat 9, then a normal readback.
    beats_seen = 0;
    push_stream(-50, 7);
    y_in = pat(-50, 7);
    out_ready = 1'b1;
    do_start(1);
    do_sweep();
    n = 0;
    while (beats_seen < 8 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("rst_at_beat9", out_index, 8);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    beats_seen = 0;
    push_stream(-7, 1);
    y_in = pat(-7, 1);
    out_ready = 1'b1;
    do_start(2);
    do_sweep();
    do_sweep();
    chk("post_rst_valid", out_valid, 1);
    wait_done(0, 100);

    // iter_count=255, with start and sweep_done in the same IDLE cycle.
    beats_seen = 0;
    push_stream(-100, 3);
    iter_count = 8'd255;
    start = 1'b1;
    sweep_done = 1'b1;
    y_in = pat(0, 1);
    tick();
    start = 1'b0;
    sweep_done = 1'b0;
    for (int i = 1; i < 255; i++) begin
      y_in = pat(i, 1);
      do_sweep();
    end
    chk("iter255_waiting", out_valid, 0);
    chk("iter255_busy", busy, 1);
    y_in = pat(-100, 3);
    do_sweep();
    chk("iter255_capture", out_valid, 1);
    wait_done(0, 100);

    // Convergence: iter 10, identical y_in from sweep 2 onward.
    beats_seen = 0;
    push_stream(-120, 13);
    do_start(10);
    cap = 0;
    for (int s = 1; s <= 12 && cap == 0; s++) begin
      y_in = (s == 1) ? pat(1, 1) : pat(-120, 13);
      do_sweep();
      if (out_valid) cap = s;
    end
`ifdef CNN_CONV_CHECK_EN
    chk("conv_capture_sweep", cap, 3);
    chk("conv_flag", converged, 1);
`else
    chk("conv_capture_sweep", cap, 10);
    chk("conv_flag", converged, 0);
`endif
    wait_done(0, 100);
`ifdef CNN_CONV_CHECK_EN
    chk("conv_hold", converged, 1);
`else
    chk("conv_hold", converged, 0);
`endif
    do_start(1);
    chk("conv_cleared", converged, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
